// File: rtl/qc_ldpc_syndrome_checker.sv
// QC-LDPC syndrome checker: XOR-accumulates circulant-rotated codeword blocks into H*c.
// Optional saturating error counter enabled by defining QC_LDPC_SYN_ERR_COUNT_EN.
module qc_ldpc_syndrome_checker #(
    parameter int MB = 2,
    parameter int NB = 4,
    parameter logic [MB*NB*5-1:0] H_BASE = {5'h10, 5'h12, 5'h10, 5'h00,
                                            5'h10, 5'h00, 5'h11, 5'h10}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_blk,
    output logic             syn_valid,
    input  logic             syn_ready,
    output logic [MB*16-1:0] syndrome,
    output logic             syn_ok
`ifdef QC_LDPC_SYN_ERR_COUNT_EN
    ,
    output logic [15:0]      err_count
`endif
);

    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [MB*16-1:0]  r_acc;
    logic              r_in_ready;
    logic              r_syn_valid;
    logic              r_syn_ok;
    logic [MB*16-1:0]  w_acc_next;
    logic [4:0]        w_ent [MB];
    logic              w_accept;

    // Bit r of the result takes x[(r+s) mod 16], i.e. a right rotate by s.
    function automatic logic [15:0] rot(input logic [15:0] x, input logic [3:0] s);
        logic [31:0] d;
        d = {x, x} >> s;
        return d[15:0];
    endfunction

    assign w_accept = in_valid && r_in_ready;

    // Accumulators are zero in IDLE, so the first block needs no separate load path.
    always_comb begin
        w_acc_next = r_acc;
        for (int unsigned i = 0; i < MB; i++) begin
            w_ent[i] = '0;
            for (int unsigned j = 0; j < NB; j++) begin
                if (CW'(j) == r_cnt) begin
                    w_ent[i] = H_BASE[(i*NB + j)*5 +: 5];
                end
            end
            if (w_ent[i][4]) begin
                w_acc_next[i*16 +: 16] = r_acc[i*16 +: 16] ^ rot(in_blk, w_ent[i][3:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_syn_valid <= 1'b0;
            r_syn_ok    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        if (r_cnt == LAST) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_syn_valid <= 1'b1;
                            r_syn_ok    <= ~|w_acc_next;
                        end else begin
                            r_state <= S_ACCUM;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (syn_ready) begin
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        r_acc       <= '0;
                        r_in_ready  <= 1'b1;
                        r_syn_valid <= 1'b0;
                        r_syn_ok    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef QC_LDPC_SYN_ERR_COUNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (r_syn_valid && syn_ready && !r_syn_ok && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign in_ready  = r_in_ready;
    assign syn_valid = r_syn_valid;
    assign syndrome  = r_acc;
    assign syn_ok    = r_syn_ok;

endmodule
